// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, req/ack imem handshake, one-entry
// stall buffer, branch redirect with in-flight squash, and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic        ifidValid,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPc4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);
    typedef enum logic [1:0] {IDLE, FETCH, FULL, SQUASH} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] buf_pc4, buf_pc4_n;
    logic        ifid_valid_n;
    logic [31:0] ifid_instr_n, ifid_pc4_n;
    logic [31:0] addr4;
    logic [31:0] target;
    logic        unused_bits;

    assign addr4       = req_addr + 32'd4;
    assign target      = {branchTarget[31:2], 2'b00};
    assign unused_bits = ^branchTarget[1:0];

    assign imemAddr = req_addr;
    assign opcode   = ifidInstr[31:26];
    assign funct    = ifidInstr[5:0];

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state, request output and next datapath values; branch overrides all.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_addr_n   = req_addr;
        buf_instr_n  = buf_instr;
        buf_pc4_n    = buf_pc4;
        ifid_valid_n = ifidValid;
        ifid_instr_n = ifidInstr;
        ifid_pc4_n   = ifidPc4;
        imemReq      = 1'b0;

        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                imemReq = 1'b1;
                if (imemAck && !stall) begin
                    ifid_valid_n = 1'b1;
                    ifid_instr_n = imemRdata;
                    ifid_pc4_n   = addr4;
                    pc_n         = addr4;
                    req_addr_n   = addr4;
                end else if (imemAck) begin
                    // Downstream is stalled: park the word, keep IF/ID.
                    buf_instr_n = imemRdata;
                    buf_pc4_n   = addr4;
                    pc_n        = addr4;
                    state_n     = FULL;
                end else if (!stall) begin
                    ifid_valid_n = 1'b0;
                    ifid_instr_n = 32'd0;
                end
            end
            FULL: begin
                if (!stall) begin
                    ifid_valid_n = 1'b1;
                    ifid_instr_n = buf_instr;
                    ifid_pc4_n   = buf_pc4;
                    req_addr_n   = pc;
                    state_n      = FETCH;
                end
            end
            SQUASH: begin
                // Old request must still complete before we may re-address.
                imemReq = 1'b1;
                if (imemAck) begin
                    req_addr_n = pc;
                    state_n    = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase

        if (branchTaken) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = 32'd0;
            ifid_pc4_n   = 32'd0;
            buf_instr_n  = 32'd0;
            buf_pc4_n    = 32'd0;
            pc_n         = target;
            if (state == SQUASH || (state == FETCH && !imemAck)) begin
                // Request in flight: hold its address, drop its data later.
                req_addr_n = req_addr;
                state_n    = SQUASH;
            end else begin
                req_addr_n = target;
                state_n    = FETCH;
            end
        end
    end

    // PC, request address, holding buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
            ifidValid <= 1'b0;
            ifidInstr <= 32'd0;
            ifidPc4   <= 32'd0;
        end else begin
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            buf_instr <= buf_instr_n;
            buf_pc4   <= buf_pc4_n;
            ifidValid <= ifid_valid_n;
            ifidInstr <= ifid_instr_n;
            ifidPc4   <= ifid_pc4_n;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand sequences for branch/squash,
// stall-buffer, address wrap and asynchronous reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branchTaken, imemAck;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr, imemRdata;
    logic        ifidValid;
    logic [31:0] ifidInstr, ifidPc4;
    logic [5:0]  opcode, funct;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemRdata(imemRdata), .ifidValid(ifidValid),
        .ifidInstr(ifidInstr), .ifidPc4(ifidPc4), .opcode(opcode), .funct(funct)
    );

    always #5 clk = ~clk;

    // Memory model: word content is a fixed scramble of its address.
    function automatic logic [31:0] m(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction
    assign imemRdata = m(imemAddr);

    typedef struct {
        logic        st, br, ack;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr, pc4;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, br, input logic [31:0] tgt, input logic ack,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] instr, pc4);
        vec_t r;
        r.st = st; r.br = br; r.tgt = tgt; r.ack = ack; r.req = req;
        r.addr = addr; r.v = v; r.instr = instr; r.pc4 = pc4;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, settle briefly.
    task automatic apply(input logic st, br, input logic [31:0] tgt, input logic ack);
        stall = st; branchTaken = br; branchTarget = tgt; imemAck = ack;
        #1;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr, pc4);
        logic [31:0] e;
        e = instr;
        chk({tag, ".valid"}, {31'd0, ifidValid}, {31'd0, v});
        chk({tag, ".instr"}, ifidInstr, instr);
        chk({tag, ".pc4"}, ifidPc4, pc4);
        chk({tag, ".opcode"}, {26'd0, opcode}, {26'd0, e[31:26]});
        chk({tag, ".funct"}, {26'd0, funct}, {26'd0, e[5:0]});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, imemReq}, {31'd0, req});
        if (req) chk({tag, ".addr"}, imemAddr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        apply(0, 0, 0, 0);
        next(); next();
        // Reset state
        chk_req("rst", 0, 32'h100);
        chk("rst.addr", imemAddr, 32'h100);
        chk_ifid("rst", 0, 0, 0);

        // Cycle-by-cycle table: inputs for the cycle and the outputs seen in it.
        vecs.push_back(mk(0,0,0,1,         0,32'h100,0,0,0));                   // IDLE
        vecs.push_back(mk(0,0,0,1,         1,32'h100,0,0,0));
        vecs.push_back(mk(0,0,0,1,         1,32'h104,1,m(32'h100),32'h104));
        vecs.push_back(mk(0,1,32'h200,1,   1,32'h108,1,m(32'h104),32'h108));    // branch w/ ack
        vecs.push_back(mk(1,0,0,1,         1,32'h200,0,0,0));                   // ack + stall -> FULL
        vecs.push_back(mk(1,0,0,1,         0,32'h200,0,0,0));
        vecs.push_back(mk(1,0,0,1,         0,32'h200,0,0,0));
        vecs.push_back(mk(0,0,0,1,         0,32'h200,0,0,0));                   // release
        vecs.push_back(mk(0,0,0,1,         1,32'h204,1,m(32'h200),32'h204));
        vecs.push_back(mk(0,0,0,0,         1,32'h208,1,m(32'h204),32'h208));    // no ack -> bubble
        vecs.push_back(mk(1,0,0,0,         1,32'h208,0,0,32'h208));
        vecs.push_back(mk(0,0,0,1,         1,32'h208,0,0,32'h208));
        vecs.push_back(mk(0,1,32'h403,0,   1,32'h20C,1,m(32'h208),32'h20C));    // branch, no ack
        vecs.push_back(mk(0,0,0,0,         1,32'h20C,0,0,0));                   // SQUASH
        vecs.push_back(mk(1,0,0,1,         1,32'h20C,0,0,0));                   // squashed ack
        vecs.push_back(mk(0,0,0,1,         1,32'h400,0,0,0));
        vecs.push_back(mk(0,0,0,0,         1,32'h404,1,m(32'h400),32'h404));

        rst = 1'b0;
        foreach (vecs[i]) begin
            apply(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].ack);
            chk_req($sformatf("v%0d", i), vecs[i].req, vecs[i].addr);
            chk_ifid($sformatf("v%0d", i), vecs[i].v, vecs[i].instr, vecs[i].pc4);
            next();
        end

        // Two-cycle memory: branch one cycle after request to 0x10 is squashed.
        apply(0, 1, 32'h10, 1); next();
        apply(0, 0, 0, 0);      chk_req("lat.a", 1, 32'h10); next();
        apply(0, 1, 32'h400, 0); chk_req("lat.b", 1, 32'h10); next();
        apply(0, 0, 0, 0);      chk_req("lat.c", 1, 32'h10); chk_ifid("lat.c", 0, 0, 0); next();
        apply(0, 0, 0, 1);      chk_req("lat.d", 1, 32'h10); next();
        apply(0, 0, 0, 1);      chk_req("lat.e", 1, 32'h400); chk_ifid("lat.e", 0, 0, 0); next();

        // Branch + stall in FULL: buffered 0x404 word must be dropped.
        apply(1, 0, 0, 1);      chk_req("full.a", 1, 32'h404); chk_ifid("full.a", 1, m(32'h400), 32'h404); next();
        apply(1, 1, 32'h400, 0); chk_req("full.b", 0, 0); next();
        apply(0, 0, 0, 1);      chk_req("full.c", 1, 32'h400); chk_ifid("full.c", 0, 0, 0); next();
        apply(0, 0, 0, 0);      chk_ifid("full.d", 1, m(32'h400), 32'h404); next();

        // Two branches while squashing: last one wins.
        apply(0, 1, 32'h500, 0); chk_req("sq.a", 1, 32'h404); next();
        apply(0, 1, 32'h600, 0); chk_req("sq.b", 1, 32'h404); next();
        apply(0, 0, 0, 1);       chk_req("sq.c", 1, 32'h404); next();
        apply(0, 0, 0, 0);       chk_req("sq.d", 1, 32'h600); chk_ifid("sq.d", 0, 0, 0); next();

        // PC+4 wraps at the top of the address space.
        apply(0, 1, 32'hFFFF_FFFC, 1); next();
        apply(0, 0, 0, 1);       chk_req("wrap.a", 1, 32'hFFFF_FFFC); next();
        apply(0, 0, 0, 0);       chk_req("wrap.b", 1, 32'h0); chk_ifid("wrap.b", 1, m(32'hFFFF_FFFC), 32'h0);

        // Asynchronous reset mid-request takes effect immediately.
        #2 rst = 1'b1; #1;
        chk_req("arst", 0, 0);
        chk("arst.addr", imemAddr, 32'h100);
        chk_ifid("arst", 0, 0, 0);
        next();
        rst = 1'b0;
        apply(0, 0, 0, 1); chk_req("arst.idle", 0, 0); next();
        apply(0, 0, 0, 1); chk_req("arst.first", 1, 32'h100); next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with IF/ID pipeline register. It sits directly upstream of `ControlUnit`. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It absorbs pipeline stalls with a one-entry holding buffer and redirects on taken branches, discarding any in-flight fetch. Its registered `opcode`/`funct` slices drive `ControlUnit` directly.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold IF/ID contents this cycle.
- `branchTaken`  in  1  redirect request from EX, one-cycle pulse.
- `branchTarget`  in  32  redirect address; bits [1:0] ignored (forced 0).
- `imemReq`  out  1  fetch request valid.
- `imemAddr`  out  32  fetch word address; stable while `imemReq`=1 and `imemAck`=0.
- `imemAck`  in  1  memory accepted the request; `imemRdata` is valid this cycle; may be asserted the same cycle as `imemReq`.
- `imemRdata`  in  32  instruction word.
- `ifidValid`  out  1  IF/ID holds a real instruction.
- `ifidInstr`  out  32  IF/ID instruction; 0 (SLL NOP) when invalid.
- `ifidPc4`  out  32  fetch address + 4 of `ifidInstr`.
- `opcode`  out  6  `ifidInstr[31:26]`, to ControlUnit.
- `funct`  out  6  `ifidInstr[5:0]`, to ControlUnit.

## Operation
- Registers: `pc` (next address to fetch), `reqAddr` (drives `imemAddr`), 32-bit holding buffer, IF/ID register, FSM state.
- States:
  - IDLE: reset state; `imemReq`=0; always moves to FETCH next cycle.
  - FETCH: `imemReq`=1, `imemAddr`=`reqAddr`.
  - FULL: buffer occupied; `imemReq`=0.
  - SQUASH: request outstanding but discarded; `imemReq`=1 at the old `reqAddr`.
- FETCH, ack and !stall: IF/ID <= {1, rdata, reqAddr+4}; `pc`, `reqAddr` <= reqAddr+4; stay in FETCH.
- FETCH, ack and stall: buffer <= rdata, with its PC+4 saved; `pc` <= reqAddr+4; go to FULL. IF/ID unchanged.
- FETCH, no ack and !stall: `ifidValid` <= 0 and `ifidInstr` <= 0, which inserts a bubble.
- FETCH, no ack and stall: IF/ID holds.
- FULL and !stall: IF/ID <= buffer; `reqAddr` <= `pc`; go to FETCH.
- FULL and stall: hold everything.
- SQUASH and ack: data discarded; `reqAddr` <= `pc`; go to FETCH.
- SQUASH and no ack: stay in SQUASH.
- In SQUASH, IF/ID stays invalid regardless of `stall`.
- `branchTaken` has priority over `stall` and over normal capture:
  - IF/ID is cleared: valid 0, instr 0, pc4 0. The buffer is emptied.
  - `pc` <= {branchTarget[31:2], 2'b00}.
  - From FETCH with no ack this cycle: go to SQUASH (`reqAddr` unchanged).
  - From FETCH with ack, from FULL, or from IDLE: `reqAddr` <= target, next state FETCH; any acked data is discarded.
  - In SQUASH: `pc` <= new target, stay in SQUASH (last branch wins).
- Arithmetic: 32-bit, with PC+4 wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `imemReq`=0.
  - `pc`=`reqAddr`=`imemAddr`=RESET_PC.
  - `ifidValid`=0; `ifidInstr`, `ifidPc4`, `opcode`, `funct` all 0.
- First request: `imemReq` rises in the second cycle after reset deassertion.
- Latency: ack in cycle N (stall=0) -> instruction on IF/ID outputs after edge N+1.
- With zero-wait memory, throughput is 1 instruction/cycle, and `imemReq` stays high continuously in FETCH.
- Stall exit from FULL: the buffered instruction appears one edge after `stall` falls. The next request issues in that same cycle, at `pc`.
- Reset mid-request abandons it; no SQUASH tracking survives reset.
- `opcode`/`funct` are combinational slices of registered `ifidInstr`, with no extra delay.

## Test plan
- Reset release, RESET_PC=0x100, always-ack memory -> `imemAddr` sequence 0x100, 0x104, 0x108. IF/ID matches one cycle later with `ifidPc4`=0x104, 0x108, 0x10C.
- Stall for 3 cycles while ack=1 at 0x200 -> one word buffered, `imemReq`=0 for the stall, IF/ID holds. On release, the buffered word appears, then the 0x204 fetch follows with no loss or duplication.
- Memory 2-cycle latency, `branchTaken` (target 0x400) one cycle after a request to 0x10 -> `imemAddr` holds 0x10 until ack. That data is dropped (`ifidValid`=0), then the request goes to 0x400.
- `branchTaken` and `stall` together in FULL -> IF/ID cleared, buffer dropped, next request 0x400-target. Outputs `opcode`=0, `funct`=0.
- Two branches during SQUASH (0x500, then 0x600) -> after ack, the first new request is 0x600.
- Fetch at 0xFFFF_FFFC -> `ifidPc4`=0 and the next `imemAddr`=0. Target 0x403 -> fetch at 0x400.
